uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// APB control/status block for a UART receiver: holds baud/frame config with
// deferred commit, gates the serial line, tracks errors and frame counts.
module uart_rx_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [4:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic        uart_rx_i,
    output logic        uart_rx_o,
    output logic [31:0] delitel_o,
    output logic [3:0]  stop_bit_num_o,
    output logic [3:0]  parity_bit_mode_o,
    output logic        rx_rst_n_o,
    input  logic [3:0]  err_rx_dropped_i,
    input  logic [3:0]  err_rx_i,
    input  logic [3:0]  err_stop_i,
    input  logic        rx_tvalid_i,
    input  logic        rx_tready_i,
    output logic        irq_o
);
    localparam logic [4:0]  A_DIV     = 5'h00;
    localparam logic [4:0]  A_CFG     = 5'h04;
    localparam logic [4:0]  A_CTRL    = 5'h08;
    localparam logic [4:0]  A_STATUS  = 5'h0C;
    localparam logic [4:0]  A_IRQ_EN  = 5'h10;
    localparam logic [4:0]  A_FRAME   = 5'h14;
    localparam logic [4:0]  A_ERR     = 5'h18;
    localparam logic [31:0] DIV_RST   = 32'h0000_0364;
    localparam logic [3:0]  STOP_RST  = 4'd1;
    localparam logic [3:0]  PAR_RST   = 4'd4;
    localparam logic [3:0]  IDLE_BITS = 4'd12;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [31:0] div_pend_q, div_pend_d;
    logic [3:0]  stop_pend_q, stop_pend_d, par_pend_q, par_pend_d;
    logic        pend_q, pend_d;
    logic [31:0] delitel_q, delitel_d;
    logic [3:0]  stop_q, stop_d, par_q, par_d;
    logic        enable_q, enable_d;
    logic [2:0]  status_q, status_d;
    logic [2:0]  irq_en_q, irq_en_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [2:0]  err_lvl_q, err_lvl_d;
    logic [1:0]  sync_q, sync_d;
    logic [31:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]  idle_bits_q, idle_bits_d;
    logic [1:0]  rst_cnt_q, rst_cnt_d;
    logic        irq_q, irq_d;

    logic        access, addr_ok, bad, wr, commit, line_idle, clr_rst, trigger;
    logic [31:0] rdata;
    logic [2:0]  err_set, w1c;
    logic [1:0]  err_inc;

    always_comb begin
        access  = psel & penable;
        addr_ok = (paddr[1:0] == 2'b00) && (paddr <= A_ERR);
        bad     = access && (!addr_ok || (pwrite && paddr == A_STATUS && |pwdata[31:3]));
        wr      = access && pwrite && !bad;

        case (paddr)
            A_DIV:    rdata = div_pend_q;
            A_CFG:    rdata = {24'd0, par_pend_q, stop_pend_q};
            A_CTRL:   rdata = {31'd0, enable_q};
            A_STATUS: rdata = {29'd0, status_q};
            A_IRQ_EN: rdata = {29'd0, irq_en_q};
            A_FRAME:  rdata = {16'd0, frame_cnt_q};
            A_ERR:    rdata = {16'd0, err_cnt_q};
            default:  rdata = 32'd0;
        endcase
        prdata  = (access && addr_ok && !rst) ? rdata : 32'd0;
        pslverr = bad && !rst;

        // Line-idle detector: 12 full bit-times of continuous high on the synced line
        sync_d      = {sync_q[0], uart_rx_i};
        bit_cnt_d   = bit_cnt_q;
        idle_bits_d = idle_bits_q;
        if (!sync_q[1]) begin
            bit_cnt_d   = 32'd0;
            idle_bits_d = 4'd0;
        end else if (idle_bits_q != IDLE_BITS) begin
            if (bit_cnt_q >= delitel_q) begin
                bit_cnt_d   = 32'd0;
                idle_bits_d = idle_bits_q + 4'd1;
            end else begin
                bit_cnt_d = bit_cnt_q + 32'd1;
            end
        end
        line_idle = (idle_bits_q == IDLE_BITS);

        commit      = pend_q && (!enable_q || line_idle);
        div_pend_d  = (wr && paddr == A_DIV) ? pwdata : div_pend_q;
        stop_pend_d = (wr && paddr == A_CFG) ? pwdata[3:0] : stop_pend_q;
        par_pend_d  = (wr && paddr == A_CFG) ? pwdata[7:4] : par_pend_q;
        // A new write in the commit cycle keeps pend set for the fresh value
        pend_d      = (wr && (paddr == A_DIV || paddr == A_CFG)) ? 1'b1 : (commit ? 1'b0 : pend_q);
        delitel_d   = commit ? div_pend_q  : delitel_q;
        stop_d      = commit ? stop_pend_q : stop_q;
        par_d       = commit ? par_pend_q  : par_q;
        enable_d    = (wr && paddr == A_CTRL) ? pwdata[0] : enable_q;
        irq_en_d    = (wr && paddr == A_IRQ_EN) ? pwdata[2:0] : irq_en_q;

        err_lvl_d = {|err_stop_i, |err_rx_i, |err_rx_dropped_i};
        err_set   = err_lvl_d & ~err_lvl_q;
        w1c       = (wr && paddr == A_STATUS) ? pwdata[2:0] : 3'd0;
        status_d  = (status_q & ~w1c) | err_set;
        clr_rst   = |(status_q[2:1] & w1c[2:1] & ~err_set[2:1]);
        err_inc   = {1'b0, err_set[0]} + {1'b0, err_set[1]} + {1'b0, err_set[2]};

        err_cnt_d   = (wr && paddr == A_ERR) ? 16'd0 : sat_add16(err_cnt_q, err_inc);
        frame_cnt_d = (wr && paddr == A_FRAME) ? 16'd0
                    : sat_add16(frame_cnt_q, {1'b0, rx_tvalid_i & rx_tready_i});

        trigger   = commit || (enable_q && !enable_d) || clr_rst;
        rst_cnt_d = trigger ? 2'd2 : ((rst_cnt_q != 2'd0) ? rst_cnt_q - 2'd1 : 2'd0);
        irq_d     = |(status_q & irq_en_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_pend_q  <= DIV_RST;
            stop_pend_q <= STOP_RST;
            par_pend_q  <= PAR_RST;
            pend_q      <= 1'b0;
            delitel_q   <= DIV_RST;
            stop_q      <= STOP_RST;
            par_q       <= PAR_RST;
            enable_q    <= 1'b0;
            status_q    <= 3'd0;
            irq_en_q    <= 3'd0;
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
            err_lvl_q   <= 3'd0;
            sync_q      <= 2'b00;
            bit_cnt_q   <= 32'd0;
            idle_bits_q <= 4'd0;
            rst_cnt_q   <= 2'd2;
            irq_q       <= 1'b0;
        end else begin
            div_pend_q  <= div_pend_d;
            stop_pend_q <= stop_pend_d;
            par_pend_q  <= par_pend_d;
            pend_q      <= pend_d;
            delitel_q   <= delitel_d;
            stop_q      <= stop_d;
            par_q       <= par_d;
            enable_q    <= enable_d;
            status_q    <= status_d;
            irq_en_q    <= irq_en_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_lvl_q   <= err_lvl_d;
            sync_q      <= sync_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_bits_q <= idle_bits_d;
            rst_cnt_q   <= rst_cnt_d;
            irq_q       <= irq_d;
        end
    end

    assign pready            = 1'b1;
    assign uart_rx_o         = enable_q ? uart_rx_i : 1'b1;
    assign delitel_o         = delitel_q;
    assign stop_bit_num_o    = stop_q;
    assign parity_bit_mode_o = par_q;
    assign rx_rst_n_o        = !rst && (rst_cnt_q == 2'd0);
    assign irq_o             = irq_q;
endmodule
